// File: rtl/rmb_rr_arbiter.sv
// Round-robin arbiter: shares one downstream resource between NUM_REQ requesters, rightmost-set-bit isolate pick.
// Latency: req -> gnt 1 cycle; completion (done) -> IDLE with one bubble, so >= 3 cycles per transaction.
// Backpressure: grant offered with gnt_valid until res_ready; held through HOLD until done (or timeout).
// Optional feature: define RMB_ARB_TIMEOUT_EN to force release after TIMEOUT HOLD cycles without done.
module rmb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  input  logic               res_ready,
  input  logic               done,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // The pointer starts on the top requester so the very first pick wraps to the lowest request.
  localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_V   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic                 gnt_valid_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   mask_d;
  logic [NUM_REQ-1:0]   masked_d;
  logic [NUM_REQ-1:0]   pick_d;
  logic [NUM_REQ-1:0]   win_oh_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic                 gnt_req_live_d;

`ifdef RMB_ARB_TIMEOUT_EN
  // Counter runs 0..TIMEOUT-1 over the HOLD cycles; reaching the last value without done expires.
  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;
`endif

  // Winner selection: requests strictly above the pointer first, otherwise wrap to the lowest request.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_d[i] = (i > int'(ptr_q));
    end
    masked_d = req & mask_d;
    pick_d   = (masked_d != '0) ? masked_d : req;
    // Isolate the lowest set bit; subtraction wraps mod 2^NUM_REQ so pick_d==0 yields 0.
    win_oh_d = pick_d & ~(pick_d - ONE_V);
    win_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh_d[i]) begin
        win_idx_d = IDX_W'(i);
      end
    end
  end

  // True while the currently granted requester still holds its request line.
  always_comb begin
    gnt_req_live_d = |(req & gnt_q);
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RMB_ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RMB_ARB_TIMEOUT_EN
      // The timeout flag is a single-cycle pulse.
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q       <= win_oh_d;
            gnt_idx_q   <= win_idx_d;
            gnt_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_GRANT;
          end
        end

        S_GRANT: begin
          // Acceptance beats a same-cycle request drop.
          if (res_ready) begin
            gnt_valid_q <= 1'b0;
            state_q     <= S_HOLD;
`ifdef RMB_ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
          end else if (!gnt_req_live_d) begin
            // Requester withdrew before acceptance: release without moving the pointer.
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        S_HOLD: begin
          if (done) begin
            ptr_q       <= gnt_idx_q;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
`ifdef RMB_ARB_TIMEOUT_EN
          else if (hold_cnt_q == CNT_LAST) begin
            // Forced release still advances the pointer so a stuck owner cannot starve others.
            ptr_q       <= gnt_idx_q;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            hold_cnt_q  <= hold_cnt_q + CNT_ONE;
          end
`endif
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = busy_q;
`ifdef RMB_ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

  // Parameter legality.
  a_params_legal: assert property (@(posedge clk) (NUM_REQ >= 2) && (TIMEOUT >= 2));

  // Grant is never more than one requester.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

  // gnt_idx names the granted bit whenever a grant is out.
  a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q == '0) || gnt_q[gnt_idx_q]);

  // busy tracks exactly whether a grant is outstanding.
  a_busy_gnt: assert property (@(posedge clk) disable iff (!rst_n) busy_q == (gnt_q != '0));

  // An offered grant implies the arbiter is busy.
  a_vld_busy: assert property (@(posedge clk) disable iff (!rst_n) !gnt_valid_q || busy_q);

endmodule
